// File: rtl/multiplier_pipe_if.sv
// multiplier_pipe_if: operand/result handshake bundle for multiplier_pipe
// slave: the multiplier side (takes operands, returns y/ovf); master: its environment
interface multiplier_pipe_if #(parameter int BIT_SZ = 16);
  logic              in_valid;
  logic              in_ready;
  logic [BIT_SZ-1:0] a;
  logic [BIT_SZ-1:0] b;
  logic [1:0]        mode;
  logic              out_valid;
  logic              out_ready;
  logic [BIT_SZ-1:0] y;
  logic              ovf;
  modport slave (input in_valid, a, b, mode, out_ready, output in_ready, out_valid, y, ovf);
  modport master (output in_valid, a, b, mode, out_ready, input in_ready, out_valid, y, ovf);
endinterface

// File: rtl/multiplier_pipe.sv
// multiplier_pipe: STAGES-deep pipelined multiplier with wrap/high/saturate result select
// clk, rst_l (sync, active low); bus: in_valid/in_ready/a/b/mode in, out_valid/out_ready/y/ovf out
module multiplier_pipe #(
  parameter int BIT_SZ = 16,
  parameter int STAGES = 2,
  parameter int SIGNED = 0
) (
  input logic            clk,
  input logic            rst_l,
  multiplier_pipe_if.slave bus
);
  localparam int W = 2 * BIT_SZ;
  logic              adv;
  logic              ea;
  logic              eb;
  logic [W-1:0]      prod;
  logic [W-1:0]      pf;
  logic [1:0]        mf;
  logic              vf;
  logic              fits;
  logic [BIT_SZ-1:0] hi;
  logic [BIT_SZ-1:0] lo;
  logic [BIT_SZ-1:0] sat;
  logic [BIT_SZ-1:0] y_c;
  logic              ovf_c;
  // one global stall: the whole pipe moves only when the output slot can change
  assign adv = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = adv;
  // sign-extend (or zero-extend) to 2B bits; the low 2B bits of the product are then exact
  assign ea = (SIGNED != 0) & bus.a[BIT_SZ-1];
  assign eb = (SIGNED != 0) & bus.b[BIT_SZ-1];
  assign prod = {{BIT_SZ{ea}}, bus.a} * {{BIT_SZ{eb}}, bus.b};
  generate
    if (STAGES == 1) begin : g_one
      assign pf = prod;
      assign mf = bus.mode;
      assign vf = bus.in_valid;
    end else begin : g_pipe
      logic [STAGES-2:0] v;
      logic [W-1:0]      p [STAGES-1];
      logic [1:0]        m [STAGES-1];
      always_ff @(posedge clk) begin
        if (!rst_l) v <= '0;
        else if (adv) begin
          v[0] <= bus.in_valid;
          p[0] <= prod;
          m[0] <= bus.mode;
          for (int i = 1; i < STAGES - 1; i++) begin
            v[i] <= v[i-1];
            p[i] <= p[i-1];
            m[i] <= m[i-1];
          end
        end
      end
      assign vf = v[STAGES-2];
      assign pf = p[STAGES-2];
      assign mf = m[STAGES-2];
    end
  endgenerate
  assign hi = pf[W-1:BIT_SZ];
  assign lo = pf[BIT_SZ-1:0];
  // signed fits when the top B+1 bits are all copies of the sign
  assign fits = (SIGNED != 0) ? (&pf[W-1:BIT_SZ-1] | ~|pf[W-1:BIT_SZ-1]) : ~|hi;
  assign sat = (SIGNED != 0) ? {pf[W-1], {(BIT_SZ-1){~pf[W-1]}}} : '1;
  assign y_c = (mf == 2'b01) ? hi : (mf == 2'b10 && !fits) ? sat : lo;
  assign ovf_c = (mf != 2'b01) && !fits;
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      bus.out_valid <= 1'b0;
      bus.y <= '0;
      bus.ovf <= 1'b0;
    end else if (adv) begin
      bus.out_valid <= vf;
      bus.y <= y_c;
      bus.ovf <= ovf_c;
    end
  end
endmodule
